// File: rtl/mono_frame_packer.sv
// mono_frame_packer: ping-pong frame buffer, mono strobes (mono_sample/mono_valid) in, AXI4-Stream frames (M_AXIS_*) out, dropped_count/frame_count status
module mono_frame_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  input  logic [DATA_WIDTH-1:0] mono_sample,
  input  logic                  mono_valid,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [15:0]           dropped_count,
  output logic [15:0]           frame_count
);
  typedef enum logic {W_FILL, W_STALL} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rstate_e;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);
  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0] full_q, full_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d, ridx_q, ridx_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [15:0] dropped_q, dropped_d, frames_q, frames_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [DATA_WIDTH-1:0] mem [2*FRAME_LEN];
  logic can_wr, wsel, we, done, re, xfer, last_xfer;
  always_comb begin
    can_wr    = wstate_q == W_FILL || !full_q[~wbank_q];
    wsel      = wstate_q == W_FILL ? wbank_q : ~wbank_q;
    we        = mono_valid && can_wr;
    done      = we && widx_q == LAST;
    widx_d    = we ? widx_q + 1'b1 : widx_q;
    wbank_d   = done ? (full_q[~wsel] ? wsel : ~wsel) : (can_wr ? wsel : wbank_q);
    wstate_d  = (done ? full_q[~wsel] : !can_wr) ? W_STALL : W_FILL;
    dropped_d = dropped_q + {15'd0, mono_valid && !can_wr && dropped_q != 16'hFFFF};
    xfer      = tvalid_q && M_AXIS_TREADY;
    last_xfer = rstate_q == R_STREAM && xfer && tlast_q;
    re        = rstate_q == R_PRIME || (rstate_q == R_STREAM && xfer && !tlast_q);
    ridx_d    = re ? ridx_q + 1'b1 : ridx_q;
    tvalid_d  = rstate_q == R_PRIME ? 1'b1 : (last_xfer ? 1'b0 : tvalid_q);
    tlast_d   = rstate_q == R_PRIME || last_xfer ? 1'b0 : (re ? ridx_q == LAST : tlast_q);
    rbank_d   = last_xfer ? ~rbank_q : rbank_q;
    frames_d  = last_xfer ? frames_q + 16'd1 : frames_q;
    full_d    = full_q;
    if (done) full_d[wsel] = 1'b1;
    if (last_xfer) full_d[rbank_q] = 1'b0;
    rstate_d  = rstate_q;
    case (rstate_q)
      R_IDLE:   rstate_d = full_q[rbank_q] ? R_PRIME : R_IDLE;
      R_PRIME:  rstate_d = R_STREAM;
      R_STREAM: rstate_d = last_xfer ? (full_q[~rbank_q] ? R_PRIME : R_IDLE) : R_STREAM;
      default:  rstate_d = R_IDLE;
    endcase
  end
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      wstate_q  <= W_FILL;
      rstate_q  <= R_IDLE;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      full_q    <= 2'b00;
      widx_q    <= '0;
      ridx_q    <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      dropped_q <= '0;
      frames_q  <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      full_q    <= full_d;
      widx_q    <= widx_d;
      ridx_q    <= ridx_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      dropped_q <= dropped_d;
      frames_q  <= frames_d;
    end
  end
  always_ff @(posedge S_AXIS_ACLK) begin
    if (we) mem[{wsel, widx_q}] <= mono_sample;
  end
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) tdata_q <= '0;
    else if (re) tdata_q <= mem[{rbank_q, ridx_q}];
  end
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign dropped_count = dropped_q;
  assign frame_count   = frames_q;
endmodule
